irb_reader: RTL and testbench
=============================

Name: irb_reader

Overview:
Reads the 8x8, 8-bit processed image back out of the IRB buffer after LCD_CTRL asserts done, and streams it as pixels with a valid/ready handshake. It also accumulates a checksum.
It is the read-side counterpart of the LCD_CTRL IRB write port and sits between the IRB and the downstream display/verification path.
The IRB is a synchronous single-port RAM with one-cycle read latency.

Parameters:
DATA_W, 8, pixel width
ADDR_W, 6, IRB address width
N_PIX, 64, pixels per frame (2**ADDR_W)
SUM_W, 14, checksum width (N_PIX*255 fits)

Ports:
clk  input  1  clock, rising-edge
reset  input  1  asynchronous, active-high reset
start  input  1  one-cycle request to read one frame; ignored unless idle
col_major  input  1  scan order, sampled with start: 0 = raster (A = row*8+col), 1 = column-major (A = col*8+row)
IRB_Q  input  DATA_W  IRB read data, valid the cycle after the address is presented with IRB_CEN low
IRB_CEN  output  1  IRB chip enable, active-low
IRB_RW  output  1  IRB write enable, held 1 (read) at all times
IRB_A  output  ADDR_W  IRB address
pix_data  output  DATA_W  streamed pixel
pix_row  output  3  row index of pix_data
pix_col  output  3  column index of pix_data
pix_valid  output  1  pix_data/row/col are valid
pix_ready  input  1  downstream accepts the beat when pix_valid && pix_ready
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle pulse after the last beat is accepted
checksum  output  SUM_W  sum of all accepted pixels; holds its value after done until the next start

Behaviour:
- Reset values: IRB_CEN=1, IRB_RW=1, IRB_A=0, pix_valid=0, pix_data=0, pix_row=0, pix_col=0, busy=0, done=0, checksum=0. State=IDLE.
- Reset mid-frame aborts immediately: in-flight reads are discarded and the output buffer is cleared.
- FSM states:
  - IDLE: start=1 latches col_major, clears checksum and counters, moves to READ; busy rises next cycle.
  - READ: issues reads with addresses 0..63 in scan order, one per cycle while room is available.
  - DRAIN: entered after the 64th address is issued; waits for the buffer to empty.
  - DONE: done=1 for exactly one cycle, then IDLE, busy=0 in the same cycle done is high.
- Read issue rule:
  - A read is issued (IRB_CEN=0) only if (buffered entries + in-flight reads) < 2.
  - The 2-entry skid FIFO therefore never overflows under any pix_ready pattern.
- Data capture: IRB_Q is written into the FIFO the cycle after issue, tagged with the row/col of its address.
- Output: pix_valid = FIFO non-empty; the head entry drives pix_data/row/col. A beat completes when pix_valid && pix_ready.
- Throughput and latency:
  - With pix_ready held high, first pix_valid appears 2 cycles after start is sampled.
  - One beat per cycle follows; 64 beats in 64 consecutive cycles.
  - done asserts the cycle after the 64th beat.
- Backpressure: pix_data/row/col stay stable while pix_valid && !pix_ready. No beat is lost or duplicated.
- Checksum: checksum += pix_data on each completed beat, unsigned, width SUM_W, no wrap within a frame.
- Boundaries:
  - start while busy: ignored.
  - start in the DONE cycle: ignored.
  - pix_ready toggling every cycle: output order is unchanged.
  - Address counter stops at 63; no wrap to 0.
- Column-major address: IRB_A = {cnt[2:0], cnt[5:3]}. Raster: IRB_A = cnt.

Decomposition:
- Shared package lcd_pkg:
  - DATA_W, ADDR_W, N_PIX, IMG_DIM=8.
  - The reader state enum (IDLE, READ, DRAIN, DONE).
  - A pixel struct {data, row, col}.
- One sub-module, irb_skid_fifo: 2-entry, push/pop, full/empty and count output, async reset.

Test Plan:
- Raster, pix_ready=1, IRB preloaded mem[k]=k:
  - Beats are 0..63 with (row,col)=(k/8,k%8).
  - done pulses 1 cycle after beat 63; checksum=2016; busy low in the done cycle.
- Column-major, same image:
  - Beat sequence is 0,8,16,...,56,1,9,...,63.
  - Beat 9 is pix_data=9 with row=1,col=1.
  - checksum=2016.
- Backpressure, pix_ready alternating 1/0, all pixels 8'hFF:
  - 64 beats, no duplicates or drops.
  - Data stable while stalled; IRB_CEN never issues with 2 entries pending.
  - checksum=16320.
- pix_ready=0 for 20 cycles after start:
  - Exactly 2 reads issued, then IRB_CEN stays 1.
  - pix_data holds mem[0] until ready rises.
- Second start pulse at beat 10:
  - Ignored; frame completes normally with a single done pulse.
- reset asserted at beat 30:
  - All outputs reach reset values immediately.
  - A new start afterwards streams from address 0 with checksum restarting at 0.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared types and constants for the IRB read-back path.
package lcd_pkg;

  localparam int DATA_W  = 8;
  localparam int ADDR_W  = 6;
  localparam int N_PIX   = 2 ** ADDR_W;
  localparam int IMG_DIM = 8;
  localparam int COORD_W = 3;
  localparam int SUM_W   = 14;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } rd_state_e;

  typedef struct packed {
    logic [DATA_W-1:0]  data;
    logic [COORD_W-1:0] row;
    logic [COORD_W-1:0] col;
  } pix_t;

  // Map the scan counter to an IRB address. The image is stored raster,
  // so column-major order swaps the two 3-bit halves of the counter.
  function automatic logic [ADDR_W-1:0] scan_addr(input logic [ADDR_W-1:0] cnt,
                                                  input logic              col_major);
    return col_major ? {cnt[2:0], cnt[5:3]} : cnt;
  endfunction

endpackage

// File: rtl/irb_skid_fifo.sv
// Two-entry skid buffer holding tagged pixels between the IRB and the stream.
module irb_skid_fifo
  import lcd_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  pix_t       push_data,
  input  logic       pop,
  output pix_t       head,
  output logic       full,
  output logic       empty,
  output logic [1:0] count
);

  pix_t       mem_q [2];
  pix_t       mem_d [2];
  logic       rd_ptr_q, rd_ptr_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic [1:0] count_q, count_d;
  logic       do_push, do_pop;

  // Pointer, storage and occupancy updates for one push and/or one pop.
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch can be inferred.
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    do_pop   = pop && (count_q != 2'd0);
    do_push  = push && ((count_q != 2'd2) || do_pop);
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
  end

  // State registers; the entries themselves are cleared so an aborted frame leaves no stale pixel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: storage is reset here on purpose (two entries only); larger RAMs normally are not.
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only.
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign full  = (count_q == 2'd2);
  assign empty = (count_q == 2'd0);
  assign count = count_q;

endmodule

// File: rtl/irb_reader.sv
// Reads one 8x8 frame out of the IRB and streams it with valid/ready plus a checksum.
module irb_reader
  import lcd_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                col_major,
  input  logic [DATA_W-1:0]   IRB_Q,
  output logic                IRB_CEN,
  output logic                IRB_RW,
  output logic [ADDR_W-1:0]   IRB_A,
  output logic [DATA_W-1:0]   pix_data,
  output logic [COORD_W-1:0]  pix_row,
  output logic [COORD_W-1:0]  pix_col,
  output logic                pix_valid,
  input  logic                pix_ready,
  output logic                busy,
  output logic                done,
  output logic [SUM_W-1:0]    checksum
);

  rd_state_e          state_q, state_d;
  logic [ADDR_W-1:0]  cnt_q, cnt_d;
  logic               col_major_q, col_major_d;
  logic               inflight_q, inflight_d;
  logic [ADDR_W-1:0]  tag_q, tag_d;
  logic [SUM_W-1:0]   checksum_q, checksum_d;

  logic [ADDR_W-1:0]  rd_addr;
  logic               issue;
  logic               pop;
  logic [2:0]         occ;
  logic [1:0]         held;
  pix_t               push_pix;
  pix_t               head;
  logic               fifo_full, fifo_empty;
  logic [1:0]         fifo_count;

  // The in-flight read lands in the buffer the cycle after issue, tagged by its address.
  assign push_pix = '{data: IRB_Q, row: tag_q[5:3], col: tag_q[2:0]};

  irb_skid_fifo u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (inflight_q),
    .push_data (push_pix),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign pop  = !fifo_empty && pix_ready;
  // Entries still held after this cycle's departure, plus the read already in flight.
  assign held = fifo_count - {1'b0, pop};
  assign occ  = {1'b0, held} + {2'b00, inflight_q};

  // Next-state, read issue and checksum accumulation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    col_major_d = col_major_q;
    checksum_d  = checksum_q;
    issue       = 1'b0;
    rd_addr     = scan_addr(cnt_q, col_major_q);

    if (pop) begin
      checksum_d = checksum_q + SUM_W'(head.data);
    end

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          col_major_d = col_major;
          cnt_d       = '0;
          checksum_d  = '0;
          state_d     = ST_READ;
        end
      end
      ST_READ: begin
        // A read goes out only when the buffer is guaranteed a free slot for it.
        if (!(fifo_full && !pop) && (occ < 3'd2)) begin
          issue = 1'b1;
          if (cnt_q == ADDR_W'(N_PIX - 1)) begin
            state_d = ST_DRAIN;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if ((held == 2'd0) && !inflight_q) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    inflight_d = issue;
    tag_d      = issue ? rd_addr : tag_q;
  end

  // Reader state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      col_major_q <= 1'b0;
      inflight_q  <= 1'b0;
      tag_q       <= '0;
      checksum_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      col_major_q <= col_major_d;
      inflight_q  <= inflight_d;
      tag_q       <= tag_d;
      checksum_q  <= checksum_d;
    end
  end

  assign IRB_CEN   = !issue;
  assign IRB_RW    = 1'b1;
  assign IRB_A     = rd_addr;
  assign pix_valid = !fifo_empty;
  assign pix_data  = head.data;
  assign pix_row   = head.row;
  assign pix_col   = head.col;
  assign busy      = (state_q == ST_READ) || (state_q == ST_DRAIN);
  assign done      = (state_q == ST_DONE);
  assign checksum  = checksum_q;

endmodule

// File: tb/tb_irb_reader.sv
// Randomized self-checking bench for irb_reader with an IRB model and frame scoreboard.
module tb_irb_reader;
  import lcd_pkg::*;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              col_major = 1'b0;
  logic              pix_ready = 1'b0;
  logic [7:0]        irb_q = '0;
  logic              irb_cen, irb_rw;
  logic [5:0]        irb_a;
  logic [7:0]        pix_data;
  logic [2:0]        pix_row, pix_col;
  logic              pix_valid, busy, done;
  logic [13:0]       checksum;

  logic [7:0]        mem [64];
  int                n_checks = 0;
  int                n_pass = 0;

  always #5 clk = ~clk;

  // IRB model: synchronous single-port read, one-cycle latency.
  always @(posedge clk) if (!irb_cen) irb_q <= mem[irb_a];

  irb_reader dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .col_major (col_major),
    .IRB_Q     (irb_q),
    .IRB_CEN   (irb_cen),
    .IRB_RW    (irb_rw),
    .IRB_A     (irb_a),
    .pix_data  (pix_data),
    .pix_row   (pix_row),
    .pix_col   (pix_col),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .busy      (busy),
    .done      (done),
    .checksum  (checksum)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // k-th pixel address of a frame in the requested scan order.
  function automatic int exp_addr(input int k, input bit cm);
    return cm ? (k % 8) * 8 + k / 8 : k;
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, "_cen"},   irb_cen,   1);
    check({tag, "_rw"},    irb_rw,    1);
    check({tag, "_a"},     irb_a,     0);
    check({tag, "_valid"}, pix_valid, 0);
    check({tag, "_data"},  pix_data,  0);
    check({tag, "_rowcol"}, {pix_row, pix_col}, 0);
    check({tag, "_busy"},  busy,      0);
    check({tag, "_done"},  done,      0);
    check({tag, "_sum"},   checksum,  0);
  endtask

  // mode: 0 ready high, 1 alternating, 2 low for 20 cycles, 3 random.
  task automatic run_frame(input bit cm, input int mode, input int restart_at,
                           input bit start_in_done, input int reset_at, input int exp_sum);
    int cyc = 0, issues = 0, beats = 0, first_valid = -1, last_beat = -1;
    int done_cnt = 0, addr_err = 0, viol = 0, stab_err = 0, tail = 0, sum = 0, a;
    bit prev_stall = 0, stop = 0, restarted = 0;
    logic [13:0] prev_pix = '0;
    while (!stop) begin
      @(negedge clk);
      col_major = (cyc == 0) ? cm : 1'($urandom_range(0, 1));
      start = (cyc == 0);
      if (restart_at >= 0 && beats == restart_at && !restarted) begin
        start = 1'b1;
        restarted = 1;
      end
      if (start_in_done && last_beat >= 0 && cyc == last_beat + 1) start = 1'b1;
      if (reset_at >= 0 && beats == reset_at) begin
        reset = 1'b1;
        start = 1'b0;
        #1;
        check_reset_vals("midreset");
        @(negedge clk);
        reset = 1'b0;
        return;
      end
      case (mode)
        0:       pix_ready = 1'b1;
        1:       pix_ready = (cyc % 2) == 1;
        2:       pix_ready = cyc > 20;
        default: pix_ready = 1'($urandom_range(0, 1));
      endcase
      #1;
      if (cyc >= 1) begin
        if (cyc == 1) check("busy_rise", busy, 1);
        if (!irb_cen) begin
          if (int'(irb_a) != exp_addr(issues, cm)) addr_err++;
          if (issues - beats - int'(pix_valid && pix_ready) >= 2) viol++;
          issues++;
        end
        if (prev_stall && {pix_data, pix_row, pix_col} != prev_pix) stab_err++;
        if (mode == 2 && cyc == 20) begin
          check("stall_reads", issues, 2);
          check("stall_head", pix_data, mem[exp_addr(0, cm)]);
        end
        if (pix_valid && first_valid < 0) first_valid = cyc;
        if (done) begin
          done_cnt++;
          if (done_cnt == 1) begin
            check("done_lat", cyc, last_beat + 1);
            check("busy_in_done", busy, 0);
            check("sum_at_done", checksum, sum);
            if (exp_sum >= 0) check("sum_const", checksum, exp_sum);
          end
        end
        if (pix_valid && pix_ready) begin
          a = exp_addr(beats, cm);
          check($sformatf("beat%0d", beats), {pix_data, pix_row, pix_col},
                {mem[a], 3'(a / 8), 3'(a % 8)});
          sum += int'(pix_data);
          beats++;
          last_beat = cyc;
        end
        prev_stall = pix_valid && !pix_ready;
        prev_pix   = {pix_data, pix_row, pix_col};
        if (done_cnt > 0) tail++;
        if (tail >= 5) stop = 1;
      end
      cyc++;
      if (cyc > 1500) begin
        check("timeout", 0, 1);
        stop = 1;
      end
    end
    start = 1'b0;
    check("beats", beats, 64);
    check("issues", issues, 64);
    check("done_pulses", done_cnt, 1);
    check("addr_order", addr_err, 0);
    check("issue_room", viol, 0);
    check("stall_stable", stab_err, 0);
    check("sum_hold", checksum, sum);
    check("idle_after", busy, 0);
    if (mode == 0) check("first_valid_lat", first_valid - 1, 2);
  endtask

  initial begin
    for (int k = 0; k < 64; k++) mem[k] = 8'(k);
    #12;
    check_reset_vals("reset");
    @(negedge clk);
    reset = 1'b0;

    run_frame(1'b0, 0, -1, 1'b0, -1, 2016);
    run_frame(1'b1, 0, -1, 1'b0, -1, 2016);
    for (int k = 0; k < 64; k++) mem[k] = 8'hFF;
    run_frame(1'b0, 1, -1, 1'b0, -1, 16320);
    for (int k = 0; k < 64; k++) mem[k] = 8'(k);
    run_frame(1'b0, 2, -1, 1'b0, -1, 2016);
    run_frame(1'b0, 0, 10, 1'b1, -1, 2016);
    run_frame(1'b0, 0, -1, 1'b0, 30, -1);
    run_frame(1'b0, 0, -1, 1'b0, -1, 2016);
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < 64; k++) mem[k] = 8'($urandom_range(0, 255));
      run_frame(1'($urandom_range(0, 1)), 3, -1, 1'b0, -1, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
